// File: rtl/id_operand_scoreboard_if.sv
// -----------------------------------------------------------------------------
// id_operand_scoreboard_if
// Bundles the decode-stage operand-resolution signals: the decode slot,
// regfile read data, bypass sources, long-latency writeback, and the resolved
// operands / stall / fire / stall counter returned by the scoreboard.
//   master : pipeline side (drives decode, regfile, bypass and writeback)
//   slave  : id_operand_scoreboard (returns operands, stall, fire, counter)
// -----------------------------------------------------------------------------
interface id_operand_scoreboard_if #(
   parameter int XLEN          = 64,
   parameter int RF_ADDR_WIDTH = 5,
   parameter int FW_PORTS      = 2,
   parameter int CNT_WIDTH     = 32
);
   // decode slot
   logic                              id_valid;
   logic                              id_ready;
   logic                              id_flush;
   logic [RF_ADDR_WIDTH-1:0]          id_rs1_addr;
   logic [RF_ADDR_WIDTH-1:0]          id_rs2_addr;
   logic                              id_rs1_used;
   logic                              id_rs2_used;
   logic                              id_req_rf;
   logic [RF_ADDR_WIDTH-1:0]          id_rd_addr;
   logic                              id_long_lat;
   // regfile read data
   logic [XLEN-1:0]                   rf_rdata1;
   logic [XLEN-1:0]                   rf_rdata2;
   // bypass sources, index 0 = youngest / highest priority
   logic [FW_PORTS-1:0]               fw_valid;
   logic [FW_PORTS-1:0]               fw_ready;
   logic [FW_PORTS*RF_ADDR_WIDTH-1:0] fw_addr;
   logic [FW_PORTS*XLEN-1:0]          fw_data;
   // long-latency writeback
   logic                              ll_wb_valid;
   logic [RF_ADDR_WIDTH-1:0]          ll_wb_addr;
   logic [XLEN-1:0]                   ll_wb_data;
   // results
   logic [XLEN-1:0]                   id_rs1;
   logic [XLEN-1:0]                   id_rs2;
   logic                              id_stall;
   logic                              id_fire;
   logic [CNT_WIDTH-1:0]              stall_cnt;

   modport master (
      output id_valid, id_ready, id_flush,
      output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
      output id_req_rf, id_rd_addr, id_long_lat,
      output rf_rdata1, rf_rdata2,
      output fw_valid, fw_ready, fw_addr, fw_data,
      output ll_wb_valid, ll_wb_addr, ll_wb_data,
      input  id_rs1, id_rs2, id_stall, id_fire, stall_cnt
   );

   modport slave (
      input  id_valid, id_ready, id_flush,
      input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
      input  id_req_rf, id_rd_addr, id_long_lat,
      input  rf_rdata1, rf_rdata2,
      input  fw_valid, fw_ready, fw_addr, fw_data,
      input  ll_wb_valid, ll_wb_addr, ll_wb_data,
      output id_rs1, id_rs2, id_stall, id_fire, stall_cnt
   );
endinterface

// File: rtl/id_operand_scoreboard.sv
// -----------------------------------------------------------------------------
// id_operand_scoreboard
// Decode-stage operand resolver. Each source operand is taken from x0 (zero),
// the highest-priority matching bypass port, the long-latency writeback, or
// the regfile, in that order. A per-register busy scoreboard tracks in-flight
// long-latency writers and, together with non-ready bypass matches (load-use),
// produces the decode stall. Stalled valid cycles are counted.
// Ports:
//   clk    : pipeline clock
//   rst_n  : asynchronous active-low reset (clears scoreboard and counter)
//   bus    : slave side of id_operand_scoreboard_if (decode slot, regfile
//            data, bypass ports, ll writeback in; operands/stall/fire/count out)
// -----------------------------------------------------------------------------
module id_operand_scoreboard #(
   parameter int XLEN          = 64,
   parameter int RF_ADDR_WIDTH = 5,
   parameter int FW_PORTS      = 2,
   parameter int CNT_WIDTH     = 32
) (
   input logic                    clk,
   input logic                    rst_n,
   id_operand_scoreboard_if.slave bus
);

   localparam int NUM_REGS = 2**RF_ADDR_WIDTH;

   typedef logic [RF_ADDR_WIDTH-1:0] addr_t;
   typedef logic [XLEN-1:0]          data_t;

   typedef struct packed {
      data_t data;
      logic  hazard;
   } operand_t;

   logic [NUM_REGS-1:0]  busy_q;
   logic [NUM_REGS-1:0]  busy_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q;
   operand_t             op1;
   operand_t             op2;
   logic                 stall;
   logic                 fire;
   logic                 set_busy;

   // Resolve one source. The first matching bypass port decides both data and
   // readiness, so an older ready port can never hide a younger load-use hit.
   // A busy register is only a hazard when nothing in flight supplies it.
   function automatic operand_t resolve(
      input addr_t                             addr,
      input logic                              used,
      input data_t                             rf_data,
      input logic [FW_PORTS-1:0]               fw_valid,
      input logic [FW_PORTS-1:0]               fw_ready,
      input logic [FW_PORTS*RF_ADDR_WIDTH-1:0] fw_addr,
      input logic [FW_PORTS*XLEN-1:0]          fw_data,
      input logic                              ll_valid,
      input addr_t                             ll_addr,
      input data_t                             ll_data,
      input logic [NUM_REGS-1:0]               busy
   );
      operand_t res;
      logic     hit;
      res.data   = rf_data;
      res.hazard = 1'b0;
      hit        = 1'b0;
      if (addr == '0) begin
         res.data = '0;
      end else begin
         for (int i = 0; i < FW_PORTS; i++) begin
            if (!hit && fw_valid[i] &&
                (fw_addr[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] == addr)) begin
               hit        = 1'b1;
               res.data   = fw_data[i*XLEN +: XLEN];
               res.hazard = used & ~fw_ready[i];
            end
         end
         if (!hit) begin
            if (ll_valid && (ll_addr == addr)) begin
               res.data = ll_data;
            end else begin
               res.hazard = used & busy[addr];
            end
         end
      end
      return res;
   endfunction

   assign op1 = resolve(bus.id_rs1_addr, bus.id_rs1_used, bus.rf_rdata1,
                        bus.fw_valid, bus.fw_ready, bus.fw_addr, bus.fw_data,
                        bus.ll_wb_valid, bus.ll_wb_addr, bus.ll_wb_data, busy_q);
   assign op2 = resolve(bus.id_rs2_addr, bus.id_rs2_used, bus.rf_rdata2,
                        bus.fw_valid, bus.fw_ready, bus.fw_addr, bus.fw_data,
                        bus.ll_wb_valid, bus.ll_wb_addr, bus.ll_wb_data, busy_q);

   assign stall    = bus.id_valid & (op1.hazard | op2.hazard);
   assign fire     = bus.id_valid & bus.id_ready & ~stall & ~bus.id_flush;
   assign set_busy = fire & bus.id_req_rf & bus.id_long_lat & (bus.id_rd_addr != '0);

   assign bus.id_rs1    = op1.data;
   assign bus.id_rs2    = op2.data;
   assign bus.id_stall  = stall;
   assign bus.id_fire   = fire;
   assign bus.stall_cnt = stall_cnt_q;

   // Scoreboard next state: flush kills everything; otherwise clear on
   // writeback first so a same-cycle re-issue to that rd leaves it busy.
   always_comb begin
      // NOTE: busy_d gets its full default before any branch, so no path
      // leaves it unassigned and no latch is inferred.
      busy_d = busy_q;
      if (bus.id_flush) begin
         busy_d = '0;
      end else begin
         if (bus.ll_wb_valid) busy_d[bus.ll_wb_addr] = 1'b0;
         if (set_busy)        busy_d[bus.id_rd_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the busy array is a small flop bank, not RAM; it must be reset
         // so a reset mid-divide cannot leave a stale writer that stalls forever.
         busy_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge
         // values regardless of statement order.
         busy_q <= busy_d;
         if (stall && !bus.id_flush) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_id_operand_scoreboard.sv
module tb_id_operand_scoreboard;

   localparam int XLEN          = 64;
   localparam int RF_ADDR_WIDTH = 5;
   localparam int FW_PORTS      = 2;
   localparam int CNT_WIDTH     = 32;
   localparam int NUM_REGS      = 2**RF_ADDR_WIDTH;

   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   // stimulus-side bypass ports, packed onto the bus by pack_fw()
   logic                     fw_valid_a [FW_PORTS];
   logic                     fw_ready_a [FW_PORTS];
   logic [RF_ADDR_WIDTH-1:0] fw_addr_a  [FW_PORTS];
   logic [XLEN-1:0]          fw_data_a  [FW_PORTS];

   // reference state
   bit   [NUM_REGS-1:0]      m_busy;
   bit   [CNT_WIDTH-1:0]     m_cnt;

   id_operand_scoreboard_if #(
      .XLEN(XLEN), .RF_ADDR_WIDTH(RF_ADDR_WIDTH),
      .FW_PORTS(FW_PORTS), .CNT_WIDTH(CNT_WIDTH)
   ) bus ();

   id_operand_scoreboard #(
      .XLEN(XLEN), .RF_ADDR_WIDTH(RF_ADDR_WIDTH),
      .FW_PORTS(FW_PORTS), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pack_fw();
      for (int i = 0; i < FW_PORTS; i++) begin
         bus.fw_valid[i]                                   = fw_valid_a[i];
         bus.fw_ready[i]                                   = fw_ready_a[i];
         bus.fw_addr[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]     = fw_addr_a[i];
         bus.fw_data[i*XLEN +: XLEN]                       = fw_data_a[i];
      end
   endtask

   task automatic idle();
      bus.id_valid    = 1'b0;
      bus.id_ready    = 1'b0;
      bus.id_flush    = 1'b0;
      bus.id_rs1_addr = '0;
      bus.id_rs2_addr = '0;
      bus.id_rs1_used = 1'b0;
      bus.id_rs2_used = 1'b0;
      bus.id_req_rf   = 1'b0;
      bus.id_rd_addr  = '0;
      bus.id_long_lat = 1'b0;
      bus.rf_rdata1   = 64'hAAAA_0000_0000_0001;
      bus.rf_rdata2   = 64'hBBBB_0000_0000_0002;
      bus.ll_wb_valid = 1'b0;
      bus.ll_wb_addr  = '0;
      bus.ll_wb_data  = '0;
      for (int i = 0; i < FW_PORTS; i++) begin
         fw_valid_a[i] = 1'b0;
         fw_ready_a[i] = 1'b0;
         fw_addr_a[i]  = '0;
         fw_data_a[i]  = '0;
      end
      pack_fw();
   endtask

   // Reference operand rule: scan ports oldest to youngest so the youngest
   // match is the one left standing.
   function automatic void model_resolve(
      input  logic [RF_ADDR_WIDTH-1:0] addr,
      input  logic                     used,
      input  logic [XLEN-1:0]          rf,
      output logic [XLEN-1:0]          data,
      output bit                       haz
   );
      int sel;
      sel = -1;
      for (int i = FW_PORTS-1; i >= 0; i--)
         if (fw_valid_a[i] && fw_addr_a[i] == addr) sel = i;
      haz = 1'b0;
      if (addr == 0) begin
         data = '0;
      end else if (sel >= 0) begin
         data = fw_data_a[sel];
         haz  = used && !fw_ready_a[sel];
      end else if (bus.ll_wb_valid && bus.ll_wb_addr == addr) begin
         data = bus.ll_wb_data;
      end else begin
         data = rf;
         haz  = used && m_busy[addr];
      end
   endfunction

   // Called at posedge+1 with inputs already set: checks combinational
   // outputs mid-cycle, advances the model, then checks the counter.
   task automatic run_cycle(input string tag);
      logic [XLEN-1:0] e1, e2;
      bit h1, h2, e_stall, e_fire;
      pack_fw();
      #2;
      model_resolve(bus.id_rs1_addr, bus.id_rs1_used, bus.rf_rdata1, e1, h1);
      model_resolve(bus.id_rs2_addr, bus.id_rs2_used, bus.rf_rdata2, e2, h2);
      e_stall = bus.id_valid && (h1 || h2);
      e_fire  = bus.id_valid && bus.id_ready && !e_stall && !bus.id_flush;
      check({tag, "_rs1"},   bus.id_rs1,   e1);
      check({tag, "_rs2"},   bus.id_rs2,   e2);
      check({tag, "_stall"}, 64'(bus.id_stall), 64'(e_stall));
      check({tag, "_fire"},  64'(bus.id_fire),  64'(e_fire));
      if (bus.id_flush) begin
         m_busy = '0;
      end else begin
         if (bus.ll_wb_valid) m_busy[bus.ll_wb_addr] = 1'b0;
         if (e_fire && bus.id_req_rf && bus.id_long_lat && bus.id_rd_addr != 0)
            m_busy[bus.id_rd_addr] = 1'b1;
      end
      if (e_stall && !bus.id_flush) m_cnt = m_cnt + 1;
      @(posedge clk);
      #1;
      check({tag, "_cnt"}, 64'(bus.stall_cnt), 64'(m_cnt));
   endtask

   task automatic reader(input logic [RF_ADDR_WIDTH-1:0] a1, input logic [RF_ADDR_WIDTH-1:0] a2);
      idle();
      bus.id_valid    = 1'b1;
      bus.id_ready    = 1'b1;
      bus.id_rs1_addr = a1;
      bus.id_rs2_addr = a2;
      bus.id_rs1_used = 1'b1;
      bus.id_rs2_used = 1'b1;
   endtask

   task automatic issue_long(input logic [RF_ADDR_WIDTH-1:0] rd);
      idle();
      bus.id_valid    = 1'b1;
      bus.id_ready    = 1'b1;
      bus.id_req_rf   = 1'b1;
      bus.id_long_lat = 1'b1;
      bus.id_rd_addr  = rd;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check("rst_cnt", 64'(bus.stall_cnt), 64'd0);
      m_busy = '0;
      m_cnt  = '0;
      rst_n  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      m_busy = '0;
      m_cnt  = '0;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("reset_cnt",   64'(bus.stall_cnt), 64'd0);
      check("reset_stall", 64'(bus.id_stall),  64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // x0 is never forwarded
      reader(5'd0, 5'd0);
      fw_valid_a[0] = 1'b1; fw_ready_a[0] = 1'b1; fw_addr_a[0] = 5'd0; fw_data_a[0] = 64'hDEAD;
      pack_fw(); #1;
      check("x0_rs1",   bus.id_rs1, 64'd0);
      check("x0_stall", 64'(bus.id_stall), 64'd0);
      run_cycle("x0");

      // priority between bypass ports
      reader(5'd5, 5'd0);
      fw_valid_a[0] = 1'b1; fw_ready_a[0] = 1'b1; fw_addr_a[0] = 5'd5; fw_data_a[0] = 64'h11;
      fw_valid_a[1] = 1'b1; fw_ready_a[1] = 1'b1; fw_addr_a[1] = 5'd5; fw_data_a[1] = 64'h22;
      pack_fw(); #1;
      check("prio_p0", bus.id_rs1, 64'h11);
      run_cycle("prio_both");
      fw_valid_a[0] = 1'b0;
      pack_fw(); #1;
      check("prio_p1", bus.id_rs1, 64'h22);
      run_cycle("prio_p1only");

      // younger non-ready match is not masked by an older ready one
      reader(5'd6, 5'd0);
      fw_valid_a[0] = 1'b1; fw_ready_a[0] = 1'b0; fw_addr_a[0] = 5'd6;
      fw_valid_a[1] = 1'b1; fw_ready_a[1] = 1'b1; fw_addr_a[1] = 5'd6; fw_data_a[1] = 64'h66;
      run_cycle("mask");

      // load-use stall then release
      reader(5'd0, 5'd7);
      fw_valid_a[0] = 1'b1; fw_ready_a[0] = 1'b0; fw_addr_a[0] = 5'd7;
      run_cycle("lu_stall0");
      run_cycle("lu_stall1");
      fw_ready_a[0] = 1'b1; fw_data_a[0] = 64'h55;
      pack_fw(); #1;
      check("lu_rs2",  bus.id_rs2, 64'h55);
      check("lu_fire", 64'(bus.id_fire), 64'd1);
      run_cycle("lu_go");

      // id_ready low without hazard: hold, no stall, no fire
      reader(5'd1, 5'd2);
      bus.id_ready = 1'b0;
      run_cycle("hold");

      // scoreboard: divide to x9, dependent stalls, ll bypass resolves it
      issue_long(5'd9);
      run_cycle("div9_issue");
      reader(5'd9, 5'd0);
      run_cycle("div9_wait0");
      run_cycle("div9_wait1");
      bus.ll_wb_valid = 1'b1; bus.ll_wb_addr = 5'd9; bus.ll_wb_data = 64'h1234;
      pack_fw(); #1;
      check("div9_rs1",  bus.id_rs1, 64'h1234);
      check("div9_fire", 64'(bus.id_fire), 64'd1);
      run_cycle("div9_wb");
      reader(5'd9, 5'd0);
      run_cycle("div9_clear");

      // same-cycle issue and writeback to x3: set wins; flush clears all
      issue_long(5'd3);
      run_cycle("x3_first");
      issue_long(5'd3);
      bus.ll_wb_valid = 1'b1; bus.ll_wb_addr = 5'd3; bus.ll_wb_data = 64'h33;
      run_cycle("x3_setclr");
      reader(5'd3, 5'd0);
      run_cycle("x3_still_busy");
      issue_long(5'd8);
      bus.id_flush = 1'b1;
      run_cycle("flush");
      reader(5'd3, 5'd8);
      run_cycle("post_flush");

      // reset mid-stall with a pending writer to x4
      pulse_reset();
      issue_long(5'd4);
      run_cycle("x4_issue");
      reader(5'd4, 5'd0);
      for (int i = 0; i < 10; i++) run_cycle("x4_wait");
      check("x4_cnt10", 64'(bus.stall_cnt), 64'd10);
      rst_n = 1'b0;
      #1;
      check("midrst_cnt", 64'(bus.stall_cnt), 64'd0);
      m_busy = '0;
      m_cnt  = '0;
      check("midrst_stall", 64'(bus.id_stall), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      reader(5'd4, 5'd0);
      run_cycle("x4_after_rst");

      // randomized traffic on a narrow register window to force collisions
      for (int n = 0; n < 400; n++) begin
         bus.id_valid    = 1'($urandom_range(0, 3) != 0);
         bus.id_ready    = 1'($urandom_range(0, 3) != 0);
         bus.id_flush    = 1'($urandom_range(0, 15) == 0);
         bus.id_rs1_addr = 5'($urandom_range(0, 7));
         bus.id_rs2_addr = 5'($urandom_range(0, 7));
         bus.id_rs1_used = 1'($urandom);
         bus.id_rs2_used = 1'($urandom);
         bus.id_req_rf   = 1'($urandom);
         bus.id_rd_addr  = 5'($urandom_range(0, 7));
         bus.id_long_lat = 1'($urandom_range(0, 2) == 0);
         bus.rf_rdata1   = {$urandom, $urandom};
         bus.rf_rdata2   = {$urandom, $urandom};
         bus.ll_wb_valid = 1'($urandom_range(0, 3) == 0);
         bus.ll_wb_addr  = 5'($urandom_range(0, 7));
         bus.ll_wb_data  = {$urandom, $urandom};
         for (int i = 0; i < FW_PORTS; i++) begin
            fw_valid_a[i] = 1'($urandom_range(0, 2) == 0);
            fw_ready_a[i] = 1'($urandom_range(0, 3) != 0);
            fw_addr_a[i]  = 5'($urandom_range(0, 7));
            fw_data_a[i]  = {$urandom, $urandom};
         end
         run_cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
